strobe_phase_tracker: RTL



---
 rtl/strobe_phase_tracker.sv | 124 ++++++++++++
 1 files changed

// File: rtl/strobe_phase_tracker.sv
// Strobe phase tracker: finds which phase of a free-running local counter an incoming
// periodic strobe occupies, locks after repeated confirmation and flywheels through misses.
//
// state  | meaning
// SEARCH | waiting for any strobe to seed a candidate phase
// VERIFY | confirming the candidate phase with consecutive on-slot strobes
// LOCKED | phase known; flywheel stb_o on every slot, misses and strays flagged
module strobe_phase_tracker #(
    parameter int PERIOD   = 20,
    parameter int LOCK_CNT = 3,
    parameter int MISS_MAX = 2,
    localparam int CW      = $clog2(PERIOD)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en_i,
    input  logic          stb_i,
    output logic          lock_o,
    output logic [CW-1:0] phase_o,
    output logic          stb_o,
    output logic          miss_o,
    output logic          err_o
);

    localparam int GW = $clog2(LOCK_CNT + 1);
    localparam int MW = $clog2(MISS_MAX + 1);

    typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] ref_cnt, ref_cnt_nx;
    logic [CW-1:0] cand, cand_nx;
    logic [CW-1:0] phase_nx;
    logic [GW-1:0] good, good_nx, good_inc;
    logic [MW-1:0] miss, miss_nx, miss_inc;
    logic          stb_nx, miss_p_nx, err_nx;

    assign good_inc = good + GW'(1);
    assign miss_inc = miss + MW'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= SEARCH;
            ref_cnt <= '0;
            cand    <= '0;
            good    <= '0;
            miss    <= '0;
            phase_o <= '0;
            lock_o  <= 1'b0;
            stb_o   <= 1'b0;
            miss_o  <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state   <= state_nx;
            ref_cnt <= ref_cnt_nx;
            cand    <= cand_nx;
            good    <= good_nx;
            miss    <= miss_nx;
            phase_o <= phase_nx;
            lock_o  <= (state_nx == LOCKED);
            stb_o   <= stb_nx;
            miss_o  <= miss_p_nx;
            err_o   <= err_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        ref_cnt_nx = ref_cnt;
        cand_nx    = cand;
        good_nx    = good;
        miss_nx    = miss;
        phase_nx   = phase_o;
        stb_nx     = 1'b0;
        miss_p_nx  = 1'b0;
        err_nx     = 1'b0;
        if (en_i) begin
            ref_cnt_nx = (ref_cnt == CW'(PERIOD - 1)) ? '0 : ref_cnt + CW'(1);
            case (state)
                SEARCH: begin
                    if (stb_i) begin
                        cand_nx  = ref_cnt;
                        good_nx  = GW'(1);
                        state_nx = VERIFY;
                    end
                end
                VERIFY: begin
                    if (ref_cnt == cand) begin
                        if (stb_i) begin
                            good_nx = good_inc;
                            if (good_inc == GW'(LOCK_CNT)) begin
                                phase_nx = cand;
                                miss_nx  = '0;
                                state_nx = LOCKED;
                            end
                        end else begin
                            state_nx = SEARCH;
                        end
                    end else if (stb_i) begin
                        // a strobe elsewhere means the candidate was wrong; reseed from it
                        cand_nx = ref_cnt;
                        good_nx = GW'(1);
                    end
                end
                LOCKED: begin
                    if (ref_cnt == phase_o) begin
                        stb_nx = 1'b1;
                        if (stb_i) begin
                            miss_nx = '0;
                        end else begin
                            miss_p_nx = 1'b1;
                            miss_nx   = miss_inc;
                            if (miss_inc == MW'(MISS_MAX)) state_nx = SEARCH;
                        end
                    end else if (stb_i) begin
                        err_nx = 1'b1;
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
    end

endmodule
